// File: rtl/rtr_route_req_sched.sv
// Per-input-port route request scheduler: holds filtered routes per VC and
// presents them round-robin to the switch allocator. Optional macro: RTR_ROUTE_SCHED_STICKY_ERRORS_EN.
module rtr_route_req_sched #(
  parameter int num_vcs              = 4,
  parameter int num_ports            = 5,
  parameter int num_resource_classes = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [num_vcs-1:0]                     route_valid_ivc,
  input  logic [num_vcs*num_ports-1:0]           route_op_ivc,
  input  logic [num_vcs*num_resource_classes-1:0] route_orc_ivc,
  input  logic [num_vcs*2-1:0]                   route_errors_ivc,
  input  logic                                   gnt,
  output logic                                   req,
  output logic [num_vcs-1:0]                     req_ivc,
  output logic [num_ports-1:0]                   req_op,
  output logic [num_resource_classes-1:0]        req_orc,
  output logic [num_vcs-1:0]                     pend_ivc,
  output logic [2:0]                             errors
);

  localparam int VW = (num_vcs > 1) ? $clog2(num_vcs) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                          state;
  logic [VW-1:0]                   ptr;
  logic [VW-1:0]                   sel;
  logic [num_vcs-1:0]              pend;
  logic [num_ports-1:0]            op_q  [num_vcs];
  logic [num_resource_classes-1:0] orc_q [num_vcs];

  logic [num_vcs-1:0]              valid_v, nz_v, err_port_v, err_cls_v;
  logic [num_ports-1:0]            op_v  [num_vcs];
  logic [num_resource_classes-1:0] orc_v [num_vcs];
  logic [num_vcs-1:0]              granted, load_ok, overload, zero_op, pend_nxt;
  logic                            gnt_fire;
  logic [2:0]                      err_now;

  logic [num_vcs-1:0]              cand;
  logic [VW-1:0]                   start_idx, next_ptr, pick, idx;
  logic                            found;

  function automatic logic [VW-1:0] wrap_add(input logic [VW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= num_vcs) s = s - num_vcs;
    return VW'(s);
  endfunction

  // VC 0 occupies the MSB of every per-VC vector on the ports.
  function automatic logic [num_vcs-1:0] vc_onehot(input logic [VW-1:0] v);
    logic [num_vcs-1:0] r;
    r = '0;
    r[VW'(num_vcs-1) - v] = 1'b1;
    return r;
  endfunction

  assign gnt_fire = (state == REQ) && gnt;
  assign next_ptr = wrap_add(sel, 1);

  for (genvar v = 0; v < num_vcs; v++) begin : g_vc
    localparam int S = num_vcs - 1 - v;
    assign valid_v[v]    = route_valid_ivc[S];
    assign op_v[v]       = route_op_ivc[S*num_ports +: num_ports];
    assign orc_v[v]      = route_orc_ivc[S*num_resource_classes +: num_resource_classes];
    assign err_port_v[v] = route_errors_ivc[S*2+1];
    assign err_cls_v[v]  = route_errors_ivc[S*2];
    assign nz_v[v]       = |op_v[v];
    assign granted[v]    = gnt_fire && (sel == VW'(v));
    // A granted VC frees its slot in the same edge, so a reload is accepted.
    assign load_ok[v]    = valid_v[v] && nz_v[v] && (!pend[v] || granted[v]);
    assign overload[v]   = valid_v[v] && nz_v[v] && pend[v] && !granted[v];
    assign zero_op[v]    = valid_v[v] && !nz_v[v];
    assign pend_nxt[v]   = load_ok[v] || (pend[v] && !granted[v]);
    assign pend_ivc[S]   = pend[v];

    always_ff @(posedge clk) begin
      if (load_ok[v]) begin
        op_q[v]  <= op_v[v];
        orc_q[v] <= orc_v[v];
      end
    end
  end

  assign err_now[0] = |(valid_v & err_port_v) || |zero_op;
  assign err_now[1] = |(valid_v & err_cls_v);
  assign err_now[2] = |overload || ((state == IDLE) && gnt);

  // Round-robin pick over the registered pend bits; the current sel is
  // excluded while in REQ so the next winner is ready on a grant.
  always_comb begin
    cand      = pend;
    start_idx = ptr;
    if (state == REQ) begin
      cand[sel] = 1'b0;
      start_idx = next_ptr;
    end
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = num_vcs - 1; i >= 0; i--) begin
      idx = wrap_add(start_idx, i);
      if (cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      pend    <= '0;
      req     <= 1'b0;
      req_ivc <= '0;
      req_op  <= '0;
      req_orc <= '0;
      errors  <= '0;
    end else begin
      pend <= pend_nxt;
`ifdef RTR_ROUTE_SCHED_STICKY_ERRORS_EN
      errors <= errors | err_now;
`else
      errors <= err_now;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            state   <= REQ;
            sel     <= pick;
            req     <= 1'b1;
            req_ivc <= vc_onehot(pick);
            req_op  <= op_q[pick];
            req_orc <= orc_q[pick];
          end
        end
        REQ: begin
          if (gnt) begin
            ptr <= next_ptr;
            if (found) begin
              sel     <= pick;
              req_ivc <= vc_onehot(pick);
              req_op  <= op_q[pick];
              req_orc <= orc_q[pick];
            end else begin
              state   <= IDLE;
              req     <= 1'b0;
              req_ivc <= '0;
              req_op  <= '0;
              req_orc <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtr_route_req_sched.sv
// Scoreboard bench for rtr_route_req_sched: a per-cycle reference model
// pushes expected outputs, a monitor pops and compares them on the falling edge.
module tb_rtr_route_req_sched;
  localparam int NV  = 4;
  localparam int NP  = 5;
  localparam int NRC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NV-1:0]     route_valid_ivc;
  logic [NV*NP-1:0]  route_op_ivc;
  logic [NV*NRC-1:0] route_orc_ivc;
  logic [NV*2-1:0]   route_errors_ivc;
  logic              gnt;
  logic              req;
  logic [NV-1:0]     req_ivc;
  logic [NP-1:0]     req_op;
  logic [NRC-1:0]    req_orc;
  logic [NV-1:0]     pend_ivc;
  logic [2:0]        errors;

  rtr_route_req_sched #(.num_vcs(NV), .num_ports(NP), .num_resource_classes(NRC)) dut (
    .clk(clk), .reset(reset),
    .route_valid_ivc(route_valid_ivc), .route_op_ivc(route_op_ivc),
    .route_orc_ivc(route_orc_ivc), .route_errors_ivc(route_errors_ivc),
    .gnt(gnt), .req(req), .req_ivc(req_ivc), .req_op(req_op), .req_orc(req_orc),
    .pend_ivc(pend_ivc), .errors(errors)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic           req;
    logic [NV-1:0]  ivc;
    logic [NP-1:0]  op;
    logic [NRC-1:0] orc;
    logic [NV-1:0]  pend;
    logic [2:0]     errors;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e;

  // Reference model: which VC is being requested (-1 = none), pending flags,
  // stored routes and the round-robin start point, all indexed by VC number.
  bit             m_pend[NV];
  logic [NP-1:0]  m_op[NV];
  logic [NRC-1:0] m_orc[NV];
  int             m_cur = -1;
  int             m_ptr = 0;
  logic [2:0]     m_err = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_pending(input int excl);
    int idx;
    for (int i = 0; i < NV; i++) begin
      idx = (m_ptr + i) % NV;
      if (m_pend[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [2:0]     err;
    int             gv;
    snap_t          e;
    logic           vld;
    logic [NP-1:0]  op;
    logic [NRC-1:0] orc;
    logic [1:0]     re;
    if (reset) begin
      for (int v = 0; v < NV; v++) m_pend[v] = 1'b0;
      m_cur = -1;
      m_ptr = 0;
      m_err = '0;
    end else begin
      err = '0;
      gv  = -1;
      if (m_cur < 0) begin
        if (gnt) err[2] = 1'b1;
        m_cur = first_pending(-1);
      end else if (gnt) begin
        gv    = m_cur;
        m_ptr = (gv + 1) % NV;
        m_cur = first_pending(gv);
      end
      if (gv >= 0) m_pend[gv] = 1'b0;
      for (int v = 0; v < NV; v++) begin
        vld = 1'(route_valid_ivc >> (NV-1-v));
        op  = NP'(route_op_ivc >> ((NV-1-v)*NP));
        orc = NRC'(route_orc_ivc >> ((NV-1-v)*NRC));
        re  = 2'(route_errors_ivc >> ((NV-1-v)*2));
        if (vld) begin
          if (re[1]) err[0] = 1'b1;
          if (re[0]) err[1] = 1'b1;
          if (op == '0) err[0] = 1'b1;
          else if (m_pend[v]) err[2] = 1'b1;
          else begin
            m_pend[v] = 1'b1;
            m_op[v]   = op;
            m_orc[v]  = orc;
          end
        end
      end
`ifdef RTR_ROUTE_SCHED_STICKY_ERRORS_EN
      m_err = m_err | err;
`else
      m_err = err;
`endif
    end
    e.req    = (m_cur >= 0);
    e.ivc    = (m_cur >= 0) ? (NV'(1) << (NV-1-m_cur)) : '0;
    e.op     = (m_cur >= 0) ? m_op[m_cur] : '0;
    e.orc    = (m_cur >= 0) ? m_orc[m_cur] : '0;
    e.pend   = '0;
    for (int v = 0; v < NV; v++) e.pend = e.pend | (NV'(m_pend[v]) << (NV-1-v));
    e.errors = m_err;
    exp_q.push_back(e);
  endtask

  initial begin
    for (int v = 0; v < NV; v++) begin
      m_pend[v] = 1'b0;
      m_op[v]   = '0;
      m_orc[v]  = '0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("mon_req",     32'(req),      32'(mon_e.req));
        check("mon_req_ivc", 32'(req_ivc),  32'(mon_e.ivc));
        check("mon_req_op",  32'(req_op),   32'(mon_e.op));
        check("mon_req_orc", 32'(req_orc),  32'(mon_e.orc));
        check("mon_pend",    32'(pend_ivc), 32'(mon_e.pend));
        check("mon_errors",  32'(errors),   32'(mon_e.errors));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    route_valid_ivc  = '0;
    route_op_ivc     = '0;
    route_orc_ivc    = '0;
    route_errors_ivc = '0;
  endtask

  task automatic set_route(input int v, input logic [NP-1:0] op, input logic [NRC-1:0] orc,
                           input logic [1:0] re);
    int s;
    s = NV - 1 - v;
    route_valid_ivc  = route_valid_ivc | (NV'(1) << s);
    route_op_ivc     = (route_op_ivc & ~((NV*NP)'({NP{1'b1}}) << (s*NP))) | ((NV*NP)'(op) << (s*NP));
    route_orc_ivc    = (route_orc_ivc & ~((NV*NRC)'({NRC{1'b1}}) << (s*NRC))) | ((NV*NRC)'(orc) << (s*NRC));
    route_errors_ivc = (route_errors_ivc & ~((NV*2)'(2'b11) << (s*2))) | ((NV*2)'(re) << (s*2));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (req || pend_ivc != '0); i++) begin
      gnt = req;
      step();
    end
    gnt = 1'b0;
    check("drain_done", 32'({req, pend_ivc}), 32'(0));
  endtask

  initial begin
    logic [NP-1:0] rop;
    clear_inputs();
    gnt   = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    check("reset_req",  32'(req),      32'(0));
    check("reset_pend", 32'(pend_ivc), 32'(0));
    reset = 1'b0;

    // single load on VC1
    set_route(1, 5'b00100, 2'b01, 2'b00);
    step();
    clear_inputs();
    check("single_pend", 32'(pend_ivc), 32'(4'b0100));
    check("single_req_early", 32'(req), 32'(0));
    step();
    check("single_req",     32'(req),     32'(1));
    check("single_req_ivc", 32'(req_ivc), 32'(4'b0100));
    check("single_req_op",  32'(req_op),  32'(5'b00100));
    check("single_req_orc", 32'(req_orc), 32'(2'b01));
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    check("single_gnt_req",  32'(req),      32'(0));
    check("single_gnt_pend", 32'(pend_ivc), 32'(0));

    // hold while VC0 arrives; grant then wraps from ptr=2 to VC0
    set_route(1, 5'b10000, 2'b10, 2'b00);
    step();
    clear_inputs();
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 2) set_route(0, 5'b00001, 2'b11, 2'b00);
      step();
      clear_inputs();
      check("hold_ivc", 32'(req_ivc), 32'(4'b0100));
      check("hold_op",  32'(req_op),  32'(5'b10000));
    end
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    check("hold_next_ivc", 32'(req_ivc), 32'(4'b1000));
    check("hold_next_op",  32'(req_op),  32'(5'b00001));
    drain();

    // overload on VC2
    set_route(2, 5'b00010, 2'b01, 2'b00);
    step();
    clear_inputs();
    set_route(2, 5'b01000, 2'b10, 2'b00);
    step();
    clear_inputs();
    check("ovl_err",    32'(errors), 32'(3'b100));
    check("ovl_req_op", 32'(req_op), 32'(5'b00010));
    step();
`ifdef RTR_ROUTE_SCHED_STICKY_ERRORS_EN
    check("ovl_err_sticky", 32'(errors), 32'(3'b100));
`else
    check("ovl_err_pulse", 32'(errors), 32'(3'b000));
`endif
    drain();

    // zero op drop and class filter error on VC3
    set_route(3, 5'b00000, 2'b01, 2'b00);
    step();
    clear_inputs();
    check("zero_pend3", 32'(pend_ivc[0]), 32'(0));
    check("zero_err0",  32'(errors[0]),   32'(1));
    set_route(3, 5'b00001, 2'b01, 2'b01);
    step();
    clear_inputs();
    check("cls_err1", 32'(errors[1]), 32'(1));
    drain();

    // round-robin with gnt held high
    for (int v = 0; v < NV; v++) set_route(v, NP'(1) << v, 2'b01, 2'b00);
    gnt = 1'b1;
    step();
    clear_inputs();
    step();
    check("rr_0", 32'(req_ivc), 32'(4'b1000));
    step();
    check("rr_1", 32'(req_ivc), 32'(4'b0100));
    step();
    check("rr_2", 32'(req_ivc), 32'(4'b0010));
    step();
    check("rr_3", 32'(req_ivc), 32'(4'b0001));
    step();
    check("rr_end", 32'(req), 32'(0));
    gnt = 1'b0;

    // reset mid-request, then first request restarts from VC0
    set_route(2, 5'b00100, 2'b01, 2'b00);
    step();
    clear_inputs();
    step();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    set_route(2, 5'b01000, 2'b10, 2'b00);
    step();
    clear_inputs();
    step();
    check("rst_pre_req", 32'(req), 32'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_req",    32'(req),      32'(0));
    check("rst_pend",   32'(pend_ivc), 32'(0));
    check("rst_errors", 32'(errors),   32'(0));
    for (int v = 0; v < NV; v++) set_route(v, NP'(1) << v, 2'b10, 2'b00);
    step();
    clear_inputs();
    step();
    check("rst_first_vc0", 32'(req_ivc), 32'(4'b1000));
    drain();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      for (int v = 0; v < NV; v++) begin
        if ($urandom_range(2, 0) == 0) begin
          rop = ($urandom_range(7, 0) == 0) ? '0 : (NP'(1) << $urandom_range(NP-1, 0));
          set_route(v, rop, NRC'($urandom), ($urandom_range(9, 0) == 0) ? 2'($urandom) : 2'b00);
        end
      end
      gnt   = req ? ($urandom_range(3, 0) != 0) : ($urandom_range(19, 0) == 0);
      reset = ($urandom_range(199, 0) == 0);
      step();
    end
    clear_inputs();
    reset = 1'b0;
    gnt   = 1'b0;
    drain();
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
